// File: rtl/line_window_reader.sv
// Turns a raster pixel stream into 3x3 windows for every interior position
// using two row-deep line memories and a 3-column shift register.
module line_window_reader #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [7:0]  data_i,
  output logic [71:0] window_o,
  output logic        valid_o,
  output logic        done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  typedef enum logic {FILL, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [71:0]     window_q, window_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  // Shift register indexed [column][row]; column 2 is newest, row 2 is current row.
  logic [2:0][2:0][7:0] sh_q, sh_d;

  logic [7:0] lm1 [WIDTH];
  logic [7:0] lm2 [WIDTH];
  logic [7:0] lm1_rd, lm2_rd;
  logic [71:0] win_flat;
  logic        col_end, row_end, emit;

  assign lm1_rd  = lm1[col_q];
  assign lm2_rd  = lm2[col_q];
  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);

  // Slot k = 3*r + c is taken from the post-shift column register contents.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_flat
      assign win_flat[8*gi +: 8] = sh_d[gi % 3][gi / 3];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    sh_d     = sh_q;
    window_d = window_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    emit     = 1'b0;

    if (we_i) begin
      sh_d[0] = sh_q[1];
      sh_d[1] = sh_q[2];
      sh_d[2] = {data_i, lm1_rd, lm2_rd};

      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (state_q)
        FILL:    if (row_q == ROW_ONE && col_end) state_d = ACTIVE;
        ACTIVE:  if (row_end && col_end) state_d = FILL;
        default: state_d = FILL;
      endcase

      // Columns 0..1 never emit, so no stale left-edge window crosses a row.
      emit = (state_q == ACTIVE) && (col_q >= COL_TWO);
      if (emit) begin
        window_d = win_flat;
        valid_d  = 1'b1;
        done_d   = row_end && col_end;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      col_q    <= '0;
      row_q    <= '0;
      sh_q     <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sh_q     <= sh_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Line memories: contents are rewritten during FILL, so no reset needed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      lm2[col_q] <= lm1[col_q];
      lm1[col_q] <= data_i;
    end
  end

  assign window_o = window_q;
  assign valid_o  = valid_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_line_window_reader.sv
// Directed and randomized stimulus for line_window_reader, checked against a
// frame-image reference model kept in the bench.
module tb_line_window_reader;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic [71:0] window_o;
  logic        valid_o;
  logic        done_o;

  line_window_reader #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),
    .window_o(window_o), .valid_o(valid_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  img [H][W];
  int          mr = 0, mc = 0;
  logic [71:0] exp_win = '0;
  int          vcount, dcount;
  logic [71:0] got_first, got_last;
  bit          seen;

  localparam logic [71:0] FIRST1 = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST1  = {8'd34, 8'd33, 8'd32, 8'd24, 8'd23, 8'd22, 8'd14, 8'd13, 8'd12};
  localparam logic [71:0] FIRST2 = {8'd122, 8'd121, 8'd120, 8'd112, 8'd111, 8'd110, 8'd102, 8'd101, 8'd100};

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted pixel followed by `gap` idle cycles; checks every cycle.
  task automatic send(input logic [7:0] d, input int gap);
    logic e_valid, e_done;
    @(negedge clk);
    we_i   = 1'b1;
    data_i = d;
    img[mr][mc] = d;
    e_valid = (mr >= 2) && (mc >= 2);
    e_done  = e_valid && (mr == H-1) && (mc == W-1);
    if (e_valid)
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          exp_win[8*(3*rr+cc) +: 8] = img[mr-2+rr][mc-2+cc];
    @(posedge clk); #1;
    $display("[TB] pixel (%0d,%0d)=%0d valid=%0b done=%0b window=%h", mr, mc, d, valid_o, done_o, window_o);
    check("valid", 72'(valid_o), 72'(e_valid));
    check("done", 72'(done_o), 72'(e_done));
    check("window", window_o, exp_win);
    if (valid_o) begin
      vcount++;
      if (!seen) got_first = window_o;
      seen = 1'b1;
      got_last = window_o;
    end
    if (done_o) dcount++;
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      we_i = 1'b0;
      @(posedge clk); #1;
      check("idle_valid", 72'(valid_o), 72'd0);
      check("idle_done", 72'(done_o), 72'd0);
      check("idle_hold", window_o, exp_win);
    end
  endtask

  task automatic frame(input int base, input bit rnd, input int max_gap);
    seen = 1'b0; vcount = 0; dcount = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(rnd ? 8'($urandom) : 8'(base + 10*r + c),
             (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 72'(valid_o), 72'd0);
    check("rst_done", 72'(done_o), 72'd0);
    check("rst_window", window_o, 72'd0);
    @(negedge clk); rst = 1'b0;

    // Ramp frame, continuous
    frame(0, 1'b0, 0);
    check("f1_count", 72'(vcount), 72'd6);
    check("f1_done_count", 72'(dcount), 72'd1);
    check("f1_first", got_first, FIRST1);
    check("f1_last", got_last, LAST1);

    // Same frame with random gaps
    frame(0, 1'b0, 3);
    check("gap_count", 72'(vcount), 72'd6);
    check("gap_first", got_first, FIRST1);
    check("gap_last", got_last, LAST1);

    // Back-to-back frames
    frame(0, 1'b0, 0);
    check("b2b_a_count", 72'(vcount), 72'd6);
    frame(100, 1'b0, 0);
    check("b2b_b_count", 72'(vcount), 72'd6);
    check("b2b_b_done", 72'(dcount), 72'd1);
    check("b2b_b_first", got_first, FIRST2);

    // Reset asynchronously mid-cycle after pixel (2,1)
    for (int i = 0; i < 2*W + 2; i++) send(8'(10*(i/W) + (i%W)), 0);
    #2;
    rst = 1'b1; we_i = 1'b0;
    #1;
    check("async_valid", 72'(valid_o), 72'd0);
    check("async_done", 72'(done_o), 72'd0);
    check("async_window", window_o, 72'd0);
    @(posedge clk); #1;
    check("async_hold", window_o, 72'd0);
    @(negedge clk); rst = 1'b0;
    mr = 0; mc = 0; exp_win = '0;

    frame(0, 1'b0, 0);
    check("post_rst_count", 72'(vcount), 72'd6);
    check("post_rst_first", got_first, FIRST1);
    check("post_rst_last", got_last, LAST1);
    check("post_rst_done", 72'(dcount), 72'd1);

    // Random data, random gaps
    for (int f = 0; f < 3; f++) begin
      frame(0, 1'b1, 2);
      check("rnd_count", 72'(vcount), 72'd6);
      check("rnd_done", 72'(dcount), 72'd1);
    end

    @(negedge clk); we_i = 1'b0;
    @(posedge clk); #1;
    check("tail_valid", 72'(valid_o), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_window_reader.md
Name: line_window_reader

Overview:
- Consumer end of the line-buffer path.
- Accepts a raster pixel stream (one 8-bit pixel per we_i beat) and keeps the two previous image rows in internal line memories.
- Reads those rows back column by column and emits a complete 3x3 pixel window (72 bits) for every interior position.
- Sits between the pixel source and the Sobel kernel; no border padding.

Parameters:
- WIDTH, 640, pixels per row (>= 3).
- HEIGHT, 480, rows per frame (>= 3).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_i  input  1  pixel strobe; data_i valid this cycle.
- data_i  input  8  pixel, raster order (row-major, left to right).
- window_o  output  72  3x3 window. Slot k = 3*r + c occupies bits [8k+7:8k]. Row r=0 is the oldest row (r-2); column c=0 is the oldest column (c-2). Pixel p22 = newest pixel at [71:64].
- valid_o  output  1  window_o holds a new window this cycle (single-cycle pulse per window).
- done_o  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset (async, rst=1):
  - col/row counters = 0, FSM = FILL.
  - window_o = 0, valid_o = 0, done_o = 0.
  - Line memory contents are not cleared; they are don't-care because FILL rewrites them before use.
- Counters:
  - col counts 0..WIDTH-1; row counts 0..HEIGHT-1. Widths are $clog2 of WIDTH and HEIGHT.
  - Both advance only on we_i.
  - col wraps to 0 after WIDTH-1 and increments row.
  - row wraps to 0 after HEIGHT-1 at col WIDTH-1, i.e. end of frame. The next frame starts immediately with no gap cycles required.
- Line memories: lm1 holds row r-1, lm2 holds row r-2, each addressed by col.
  - On we_i: read lm1[col] and lm2[col] (read-before-write), then write lm2[col] <= old lm1[col] and lm1[col] <= data_i.
- Column shift registers (3 x 3 pixels):
  - On we_i: shift left one column; the new rightmost column = {lm2[col], lm1[col], data_i}.
  - Shift runs in every state so the window is primed at row starts.
- FSM:
  - FILL: rows 0..1; valid_o never asserted. Go to ACTIVE on the we_i that accepts pixel (row 1, col WIDTH-1).
  - ACTIVE: rows 2..HEIGHT-1. Go to FILL on the we_i that accepts pixel (HEIGHT-1, WIDTH-1).
- Output timing:
  - When we_i accepts pixel (r,c) with r >= 2 and c >= 2, valid_o = 1 on the next cycle.
  - window_o then equals pixels rows r-2..r, columns c-2..c. Latency is 1 clock.
  - valid_o = 0 in all other cycles. window_o holds its last value while valid_o = 0.
- done_o = 1 in the same cycle as the valid_o produced by pixel (HEIGHT-1, WIDTH-1).
- Windows per frame: (WIDTH-2)*(HEIGHT-2).
- Stalls: we_i = 0 freezes all counters, FSM, memories and shift registers. Valid_o and done_o are 0 in the following cycle. Arbitrary gaps are allowed, including mid-row and across frame boundaries.
- Row boundary: columns 0..1 of each row produce no window. A stale left-edge window must never be emitted across rows.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the next accepted pixel is treated as (0,0) of a new frame.

Test Plan:
- WIDTH=5, HEIGHT=4, pixel = 10*row+col, we_i continuous -> exactly 6 valid_o pulses, each 1 cycle after pixels 22,23,24,32,33,34. First window slots p00..p22 = 0,1,2,10,11,12,20,21,22.
- Same frame, last window -> slots p00..p22 = 12,13,14,22,23,24,32,33,34; done_o = 1 only in that cycle.
- Same frame with we_i toggling 1/0 and random 0-3 cycle gaps -> identical window sequence and count; valid_o never asserted in a cycle not directly after a we_i.
- Two back-to-back frames, second frame pixel = 100+10*row+col -> 12 windows total. First window of frame 2 = 100,101,102,110,...,122, containing no frame-1 data; done_o pulses twice.
- Assert rst for 1 cycle after pixel 21, asynchronously mid-cycle -> valid_o/done_o/window_o = 0 immediately. A full new frame then yields the first-frame results exactly.
- Default parameters (640x480), ramp data -> 638*478 = 304964 windows, one done_o; spot-check window at center (240,320).
